// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//
// Purpose:
//   Multi-cycle instruction fetch front end. It requests one instruction word
//   from instruction memory, latches it, presents its decoded fields and
//   immediate to the controller for one or more EXEC cycles, then advances
//   the PC to either PC+4 or PC+ImmExt. A target that is not word aligned
//   parks the unit in HALT with a sticky misalign flag until reset.
//
// States:
//   state | meaning
//   ------+----------------------------------------------------------------
//   FETCH | imem_req high with imem_addr = PC, waiting for imem_ack
//   EXEC  | Instr valid, issue_valid high; advance PC unless stalled
//   HALT  | misaligned target seen; idle until reset
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   imem_req, imem_addr    fetch request and address (address = PC)
//   imem_ack, imem_rdata   fetch completion and instruction word (same cycle)
//   op, funct3, funct7b5   decoded fields of the latched instruction
//   ImmSrc                 immediate format select: 00 I, 01 S, 10 B, 11 J
//   PCSrc                  next PC select: 1 PC+ImmExt, 0 PC+4
//   stall                  hold the current instruction in EXEC
//   issue_valid            Instr/ImmExt/controller outputs valid this cycle
//   Instr, PC, PCPlus4     instruction register, current PC, PC+4
//   ImmExt                 sign-extended immediate
//   misalign               sticky misaligned-target fault
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    input  logic [1:0]  ImmSrc,
    input  logic        PCSrc,
    input  logic        stall,
    output logic        issue_valid,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] ImmExt,
    output logic        misalign
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        misalign_q;
    logic [31:0] pc_target;
    logic [31:0] pc_next;
    logic        load_instr;
    logic        load_pc;
    logic        set_misalign;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= NOP;
            misalign_q <= 1'b0;
        end else begin
            state <= state_next;
            if (load_instr) begin
                instr_q <= imem_rdata;
            end
            if (load_pc) begin
                pc_q <= pc_next;
            end
            if (set_misalign) begin
                misalign_q <= 1'b1;
            end
        end
    end

    always_comb begin
        ImmExt = 32'h0000_0000;
        case (ImmSrc)
            2'b00: ImmExt = {{20{instr_q[31]}}, instr_q[31:20]};
            2'b01: ImmExt = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            2'b10: ImmExt = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                             instr_q[30:25], instr_q[11:8], 1'b0};
            2'b11: ImmExt = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                             instr_q[20], instr_q[30:21], 1'b0};
            default: ImmExt = 32'h0000_0000;
        endcase
    end

    // Both adders wrap naturally at 32 bits.
    assign PCPlus4   = pc_q + 32'd4;
    assign pc_target = pc_q + ImmExt;
    assign pc_next   = PCSrc ? pc_target : PCPlus4;

    always_comb begin
        state_next   = state;
        load_instr   = 1'b0;
        load_pc      = 1'b0;
        set_misalign = 1'b0;
        imem_req     = 1'b0;
        issue_valid  = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    load_instr = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                issue_valid = 1'b1;
                if (!stall) begin
                    if (pc_next[1:0] == 2'b00) begin
                        load_pc    = 1'b1;
                        state_next = FETCH;
                    end else begin
                        // PC keeps the address of the offending instruction.
                        set_misalign = 1'b1;
                        state_next   = HALT;
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
        // Reset takes effect on the next edge, but the handshake outputs must
        // already be quiet while it is held.
        if (reset) begin
            imem_req    = 1'b0;
            issue_valid = 1'b0;
        end
    end

    assign imem_addr = pc_q;
    assign PC        = pc_q;
    assign Instr     = instr_q;
    assign misalign  = misalign_q;
    assign op        = instr_q[6:0];
    assign funct3    = instr_q[14:12];
    assign funct7b5  = instr_q[30];

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//
// Purpose:
//   Self-checking bench for fetch_unit. Each fetch pushes the expected issue
//   record (instruction, immediate, PC) onto a scoreboard queue when the ack
//   is driven; the record is popped and compared when issue_valid appears.
//   PC progression, wait states, stalls, reset and the misalign halt are
//   checked against a bench-side PC model.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [1:0]  ImmSrc = 2'b00;
    logic        PCSrc = 1'b0;
    logic        stall = 1'b0;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        issue_valid;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] ImmExt;
    logic        misalign;

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .ImmSrc     (ImmSrc),
        .PCSrc      (PCSrc),
        .stall      (stall),
        .issue_valid(issue_valid),
        .Instr      (Instr),
        .PC         (PC),
        .PCPlus4    (PCPlus4),
        .ImmExt     (ImmExt),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] m_pc = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_compare();
        exp_t e;
        check("issue_valid", 32'(issue_valid), 32'd1);
        check("sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check("instr",    Instr, e.instr);
        check("op",       32'(op), 32'(e.instr[6:0]));
        check("funct3",   32'(funct3), 32'(e.instr[14:12]));
        check("funct7b5", 32'(funct7b5), 32'(e.instr[30]));
        check("immext",   ImmExt, e.imm);
        check("pc",       PC, e.pc);
        check("pcplus4",  PCPlus4, e.pc + 32'd4);
    endtask

    // Reset held for 3 cycles with a stray ack present; it must be ignored.
    task automatic apply_reset();
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBADC_0DE5;
        stall      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_req",      32'(imem_req), 32'd0);
            check("rst_issue",    32'(issue_valid), 32'd0);
            check("rst_pc",       PC, 32'h0000_0000);
            check("rst_instr",    Instr, 32'h0000_0013);
            check("rst_misalign", 32'(misalign), 32'd0);
        end
        reset    = 1'b0;
        imem_ack = 1'b0;
        #1;
        check("post_rst_req",  32'(imem_req), 32'd1);
        check("post_rst_addr", imem_addr, 32'h0000_0000);
        m_pc = 32'h0;
        exp_q.delete();
    endtask

    task automatic do_fetch(input logic [31:0] word, input int waits, input logic [1:0] isrc,
                            input logic psrc, input int stalls, input logic [31:0] exp_imm);
        int          n;
        logic [31:0] nxt;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen",       32'(imem_req), 32'd1);
        check("issue_in_fetch", 32'(issue_valid), 32'd0);
        for (int i = 0; i < waits; i++) begin
            check("wait_req",  32'(imem_req), 32'd1);
            check("wait_addr", imem_addr, m_pc);
            @(negedge clk);
        end
        check("fetch_addr", imem_addr, m_pc);
        exp_q.push_back('{instr: word, imm: exp_imm, pc: m_pc});
        imem_ack   = 1'b1;
        imem_rdata = word;
        ImmSrc     = isrc;
        PCSrc      = psrc;
        stall      = (stalls > 0);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        pop_compare();
        check("req_in_exec", 32'(imem_req), 32'd0);
        for (int i = 0; i < stalls; i++) begin
            imem_ack = 1'b1;
            @(negedge clk);
            check("stall_issue", 32'(issue_valid), 32'd1);
            check("stall_pc",    PC, m_pc);
            check("stall_instr", Instr, word);
        end
        stall    = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        nxt = psrc ? (m_pc + exp_imm) : (m_pc + 32'd4);
        if (nxt[1:0] == 2'b00) begin
            check("next_pc",     PC, nxt);
            check("next_req",    32'(imem_req), 32'd1);
            check("next_addr",   imem_addr, nxt);
            check("no_misalign", 32'(misalign), 32'd0);
            m_pc = nxt;
        end else begin
            imem_ack   = 1'b1;
            imem_rdata = 32'h1234_5678;
            for (int i = 0; i < 4; i++) begin
                check("halt_misalign", 32'(misalign), 32'd1);
                check("halt_req",      32'(imem_req), 32'd0);
                check("halt_issue",    32'(issue_valid), 32'd0);
                check("halt_pc",       PC, m_pc);
                check("halt_instr",    Instr, word);
                @(negedge clk);
            end
            imem_ack = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        apply_reset();
        do_fetch(32'h0050_0093, 0, 2'b00, 1'b0, 0, 32'h0000_0005);  // addi, PC 0 -> 4
        do_fetch(32'hFFF0_0093, 3, 2'b00, 1'b0, 0, 32'hFFFF_FFFF);  // addi -1, waits, 4 -> 8
        do_fetch(32'h00A1_2423, 0, 2'b01, 1'b0, 0, 32'h0000_0008);  // sw, 8 -> C
        do_fetch(32'h0050_0093, 1, 2'b00, 1'b0, 1, 32'h0000_0005);  // stall 1, C -> 10
        do_fetch(32'hFE00_0CE3, 0, 2'b10, 1'b1, 0, 32'hFFFF_FFF8);  // branch, 10 -> 8
        @(negedge clk);
        check("pre_reset_req", 32'(imem_req), 32'd1);
        apply_reset();                                               // abandon pending fetch
        do_fetch(32'h0020_006F, 0, 2'b11, 1'b1, 0, 32'h0000_0002);  // jal +2 -> HALT
        apply_reset();
        do_fetch(32'hFFDF_F06F, 0, 2'b11, 1'b1, 0, 32'hFFFF_FFFC);  // jal -4, 0 -> FFFFFFFC
        do_fetch(32'h0000_0013, 0, 2'b00, 1'b0, 2, 32'h0000_0000);  // stall 2, wrap to 0
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
